// File: rtl/mips_mem_interface_if.sv
// Control-side request/result signals and the external memory bus of the MIPS memory front-end.
// master is the front-end's view; slave is the control unit plus memory model.
interface mips_mem_interface_if;
   logic        IorD;
   logic        IRWrite;
   logic        DataRead;
   logic        MemWrite;
   logic [31:0] PC;
   logic [31:0] ALUOut;
   logic [31:0] WriteData;
   logic [31:0] Instr;
   logic [31:0] Data;
   logic        stall;
   logic        align_err;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      input  IorD, IRWrite, DataRead, MemWrite, PC, ALUOut, WriteData,
      input  mem_rdata, mem_ack,
      output Instr, Data, stall, align_err, bus_err,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output IorD, IRWrite, DataRead, MemWrite, PC, ALUOut, WriteData,
      output mem_rdata, mem_ack,
      input  Instr, Data, stall, align_err, bus_err,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips_mem_interface.sv
// Memory front-end for the multicycle MIPS core: one req/ack bus access per request, result in IR or MDR.
// Latency >= 3 cycles (launch, BUSY until ack or timeout, DONE); stall holds the control FSM while the access is outstanding.
module mips_mem_interface #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          CNT_W          = 8,
   parameter logic [31:0] IR_RESET       = 32'h0000_0000
) (
   input logic                  cclk,
   input logic                  rstb,
   mips_mem_interface_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic [1:0] {K_IR, K_MDR, K_WR} kind_t;

   state_t           state_q, state_d;
   kind_t            kind_q, kind_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic             align_q, align_d;
   logic             berr_q, berr_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      ir_q, ir_d;
   logic [31:0]      mdr_q, mdr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             access;
   logic             aligned;
   logic             tmo_hit;
   logic [31:0]      addr;

   assign access  = bus.IRWrite | bus.DataRead | bus.MemWrite;
   assign addr    = bus.IorD ? bus.ALUOut : bus.PC;
   assign aligned = (addr[1:0] == 2'b00);
   assign tmo_hit = (state_q == S_BUSY) && !bus.mem_ack &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      req_d   = req_q;
      we_d    = we_q;
      align_d = 1'b0;
      berr_d  = berr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (access && aligned) begin
               addr_d  = addr;
               wdata_d = bus.WriteData;
               we_d    = bus.MemWrite;
               req_d   = 1'b1;
               kind_d  = bus.MemWrite ? K_WR : (bus.DataRead ? K_MDR : K_IR);
               cnt_d   = '0;
               state_d = S_BUSY;
            end else if (access) begin
               align_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_BUSY: begin
            if (bus.mem_ack) begin
               case (kind_q)
                  K_IR:    ir_d  = bus.mem_rdata;
                  K_MDR:   mdr_d = bus.mem_rdata;
                  default: ;
               endcase
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = S_DONE;
            end else if (tmo_hit) begin
               berr_d  = 1'b1;
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Request inputs are stale here until the control FSM's outputs catch up.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge cclk or posedge rstb) begin
      if (rstb) begin
         state_q <= S_IDLE;
         kind_q  <= K_IR;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         align_q <= 1'b0;
         berr_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ir_q    <= IR_RESET;
         mdr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         req_q   <= req_d;
         we_q    <= we_d;
         align_q <= align_d;
         berr_q  <= berr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stall falls in the completing cycle (ack or timeout) so control advances together with DONE.
   assign bus.stall     = ((state_q == S_IDLE) && access && aligned) ||
                          ((state_q == S_BUSY) && !bus.mem_ack && !tmo_hit);
   assign bus.Instr     = ir_q;
   assign bus.Data      = mdr_q;
   assign bus.align_err = align_q;
   assign bus.bus_err   = berr_q;
   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
endmodule
